debug_run_controller: RTL and testbench

- Sequences the core's debug hooks: the `debug` flag, the per-stage pipeline enables `enable_ext[3:0]` (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable `enable_pc_ext`.
- Accepts HALT / STEP / RESUME commands decoded from the debug Avalon slave's control register.
- Also halts on a PC breakpoint and exposes halt status for readback over the same slave.
- Sits between the debug Avalon slave and the RISC-V pipeline.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/dbg_bp_match.sv | 37 +++
 rtl/debug_run_controller.sv | 156 +++++++++++++++
 tb/tb_debug_run_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: types and constants shared by the debug run controller.
//   dbg_state_t  : controller FSM states
//   dbg_cmd_t    : 2-bit command codes decoded from the debug control register
//   halt_cause_t : reason the core last entered HALTED
package debug_pkg;

    localparam int DBG_NSTAGES = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2,
        ST_RESUME = 2'd3
    } dbg_state_t;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_HALT   = 2'b01,
        CMD_STEP   = 2'b10,
        CMD_RESUME = 2'b11
    } dbg_cmd_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_HALT = 2'b01,
        CAUSE_BP   = 2'b10,
        CAUSE_STEP = 2'b11
    } halt_cause_t;

endpackage

// File: rtl/dbg_bp_match.sv
// dbg_bp_match: PC breakpoint comparator with a re-arm flop.
//   CLK, RST : clock, asynchronous active-high reset
//   bp_en    : breakpoint enable
//   bp_addr  : breakpoint address
//   pc       : current fetch PC
//   disarm   : controller is leaving HALTED this cycle
//   bp_hit   : enabled, armed and pc equals bp_addr (combinational)
// The armed flag drops when the core is released from HALTED and comes back
// only once pc has moved off the breakpoint, so a core released while parked
// on the breakpoint address does not immediately halt again.
module dbg_bp_match #(
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic            disarm,
    output logic            bp_hit
);

    logic bp_armed;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bp_armed <= 1'b1;
        end else if (disarm) begin
            bp_armed <= 1'b0;
        end else if (pc != bp_addr) begin
            bp_armed <= 1'b1;
        end
    end

    assign bp_hit = bp_en && bp_armed && (pc == bp_addr);

endmodule

// File: rtl/debug_run_controller.sv
// debug_run_controller: sequences the core's debug hooks (debug flag,
// pipeline register enables, PC enable) from HALT/STEP/RESUME commands and a
// PC breakpoint. All outputs are flops loaded from the next-state decode, so a
// command or breakpoint sampled in cycle t is visible in cycle t+1.
//   CLK, RST      : clock, asynchronous active-high reset
//   cmd_valid     : one-cycle command strobe
//   cmd_code      : 00 NOP, 01 HALT, 10 STEP, 11 RESUME
//   step_count    : steps for STEP (0 means 1)
//   bp_en/bp_addr : breakpoint enable and address
//   pc            : current fetch PC
//   debug         : core under debug control
//   enable_ext    : pipeline register enables
//   enable_pc_ext : PC register enable
//   halted        : controller is HALTED
//   cmd_ready     : commands are accepted (RUN or HALTED)
//   cmd_err       : one-cycle pulse for a dropped or illegal command
//   halt_cause    : 00 none, 01 HALT, 10 breakpoint, 11 step done
//   halt_pc       : pc captured on entry to HALTED
//   fsm_state     : current FSM state, for observation
// Handshake: a command is taken when cmd_valid is high in a cycle where
// cmd_ready is high; cmd_valid while cmd_ready is low is dropped and flagged
// on cmd_err in the following cycle. There is no back-pressure or retry.
module debug_run_controller
    import debug_pkg::*;
#(
    parameter int NSTAGES = DBG_NSTAGES,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_code,
    input  logic [CNT_W-1:0]   step_count,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    output logic               debug,
    output logic [NSTAGES-1:0] enable_ext,
    output logic               enable_pc_ext,
    output logic               halted,
    output logic               cmd_ready,
    output logic               cmd_err,
    output logic [1:0]         halt_cause,
    output logic [PC_W-1:0]    halt_pc,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] S_RUN    = ST_RUN;
    localparam logic [1:0] S_HALTED = ST_HALTED;
    localparam logic [1:0] S_STEP   = ST_STEP;
    localparam logic [1:0] S_RESUME = ST_RESUME;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       cause_nxt;
    logic             capture_pc;
    logic             err_nxt;
    logic             disarm;
    logic             bp_hit;

    dbg_bp_match #(.PC_W(PC_W)) u_bp_match (
        .CLK     (CLK),
        .RST     (RST),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .pc      (pc),
        .disarm  (disarm),
        .bp_hit  (bp_hit)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cause_nxt  = halt_cause;
        capture_pc = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            S_RUN: begin
                // Breakpoint outranks a HALT command arriving in the same cycle.
                if (bp_hit) begin
                    state_nxt  = S_HALTED;
                    cause_nxt  = CAUSE_BP;
                    capture_pc = 1'b1;
                end else if (cmd_valid && cmd_code == CMD_HALT) begin
                    state_nxt  = S_HALTED;
                    cause_nxt  = CAUSE_HALT;
                    capture_pc = 1'b1;
                end
                if (cmd_valid && (cmd_code == CMD_STEP || cmd_code == CMD_RESUME)) begin
                    err_nxt = 1'b1;
                end
            end
            S_HALTED: begin
                if (cmd_valid && cmd_code == CMD_STEP) begin
                    state_nxt = S_STEP;
                    cnt_nxt   = (step_count == '0) ? CNT_W'(1) : step_count;
                end else if (cmd_valid && cmd_code == CMD_RESUME) begin
                    state_nxt = S_RESUME;
                end
            end
            S_STEP: begin
                // Each cycle spent here is one step; the last one returns to HALTED.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt  = S_HALTED;
                    cnt_nxt    = '0;
                    cause_nxt  = CAUSE_STEP;
                    capture_pc = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
                err_nxt = cmd_valid;
            end
            S_RESUME: begin
                state_nxt = S_RUN;
                cause_nxt = CAUSE_NONE;
                err_nxt   = cmd_valid;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    assign disarm    = (state == S_HALTED) && (state_nxt == S_STEP || state_nxt == S_RESUME);
    assign fsm_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_RUN;
            cnt           <= '0;
            halt_cause    <= CAUSE_NONE;
            halt_pc       <= '0;
            cmd_err       <= 1'b0;
            debug         <= 1'b0;
            enable_ext    <= '1;
            enable_pc_ext <= 1'b1;
            halted        <= 1'b0;
            cmd_ready     <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            halt_cause    <= cause_nxt;
            if (capture_pc) begin
                halt_pc <= pc;
            end
            cmd_err       <= err_nxt;
            debug         <= (state_nxt != S_RUN);
            enable_ext    <= {NSTAGES{state_nxt != S_HALTED}};
            enable_pc_ext <= (state_nxt != S_HALTED);
            halted        <= (state_nxt == S_HALTED);
            cmd_ready     <= (state_nxt == S_RUN) || (state_nxt == S_HALTED);
        end
    end

endmodule

// File: tb/tb_debug_run_controller.sv
module tb_debug_run_controller;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [7:0]  step_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        debug;
    logic [3:0]  enable_ext;
    logic        enable_pc_ext;
    logic        halted;
    logic        cmd_ready;
    logic        cmd_err;
    logic [1:0]  halt_cause;
    logic [31:0] halt_pc;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    debug_run_controller #(.NSTAGES(4), .PC_W(32), .CNT_W(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .step_count    (step_count),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .pc            (pc),
        .debug         (debug),
        .enable_ext    (enable_ext),
        .enable_pc_ext (enable_pc_ext),
        .halted        (halted),
        .cmd_ready     (cmd_ready),
        .cmd_err       (cmd_err),
        .halt_cause    (halt_cause),
        .halt_pc       (halt_pc),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [1:0]  code;
        logic [7:0]  sc;
        logic        bpen;
        logic [31:0] bpa;
        logic [31:0] pcv;
        logic        e_dbg;
        logic [3:0]  e_en;
        logic        e_pcen;
        logic        e_hlt;
        logic        e_rdy;
        logic        e_err;
        logic [1:0]  e_cause;
        logic [31:0] e_hpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [1:0] code, input logic [7:0] sc,
                                input logic bpen, input logic [31:0] bpa, input logic [31:0] pcv,
                                input logic e_dbg, input logic [3:0] e_en, input logic e_pcen,
                                input logic e_hlt, input logic e_rdy, input logic e_err,
                                input logic [1:0] e_cause, input logic [31:0] e_hpc);
        vec_t r;
        r.v = v; r.code = code; r.sc = sc; r.bpen = bpen; r.bpa = bpa; r.pcv = pcv;
        r.e_dbg = e_dbg; r.e_en = e_en; r.e_pcen = e_pcen; r.e_hlt = e_hlt;
        r.e_rdy = e_rdy; r.e_err = e_err; r.e_cause = e_cause; r.e_hpc = e_hpc;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_dbg, input logic [3:0] e_en,
                             input logic e_pcen, input logic e_hlt, input logic e_rdy,
                             input logic e_err, input logic [1:0] e_cause, input logic [31:0] e_hpc);
        check_val({tag, ".debug"},         32'(debug),         32'(e_dbg));
        check_val({tag, ".enable_ext"},    32'(enable_ext),    32'(e_en));
        check_val({tag, ".enable_pc_ext"}, 32'(enable_pc_ext), 32'(e_pcen));
        check_val({tag, ".halted"},        32'(halted),        32'(e_hlt));
        check_val({tag, ".cmd_ready"},     32'(cmd_ready),     32'(e_rdy));
        check_val({tag, ".cmd_err"},       32'(cmd_err),       32'(e_err));
        check_val({tag, ".halt_cause"},    32'(halt_cause),    32'(e_cause));
        check_val({tag, ".halt_pc"},       halt_pc,            e_hpc);
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] code, input logic [7:0] sc,
                         input logic bpen, input logic [31:0] bpa, input logic [31:0] pcv);
        cmd_valid  = v;
        cmd_code   = code;
        step_count = sc;
        bp_en      = bpen;
        bp_addr    = bpa;
        pc         = pcv;
    endtask

    initial begin
        // codes: 0 NOP, 1 HALT, 2 STEP, 3 RESUME
        //            v  cd sc     bpen bpa     pc         dbg en    pce hlt rdy err cause hpc
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h0FC, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h0));
        vecs.push_back(mk(1, 1, 8'd0, 0, 32'h0,  32'h100, 1, 4'h0, 0, 1, 1, 0, 2'd1, 32'h100));
        vecs.push_back(mk(1, 1, 8'd0, 0, 32'h0,  32'h100, 1, 4'h0, 0, 1, 1, 0, 2'd1, 32'h100));
        vecs.push_back(mk(1, 2, 8'd3, 0, 32'h0,  32'h100, 1, 4'hF, 1, 0, 0, 0, 2'd1, 32'h100));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h104, 1, 4'hF, 1, 0, 0, 0, 2'd1, 32'h100));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h108, 1, 4'hF, 1, 0, 0, 0, 2'd1, 32'h100));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h10C, 1, 4'h0, 0, 1, 1, 0, 2'd3, 32'h10C));
        vecs.push_back(mk(1, 2, 8'd0, 0, 32'h0,  32'h110, 1, 4'hF, 1, 0, 0, 0, 2'd3, 32'h10C));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h114, 1, 4'h0, 0, 1, 1, 0, 2'd3, 32'h114));
        vecs.push_back(mk(1, 2, 8'd2, 0, 32'h0,  32'h114, 1, 4'hF, 1, 0, 0, 0, 2'd3, 32'h114));
        vecs.push_back(mk(1, 1, 8'd0, 0, 32'h0,  32'h118, 1, 4'hF, 1, 0, 0, 1, 2'd3, 32'h114));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h11C, 1, 4'h0, 0, 1, 1, 0, 2'd3, 32'h11C));
        vecs.push_back(mk(1, 3, 8'd0, 0, 32'h0,  32'h11C, 1, 4'hF, 1, 0, 0, 0, 2'd3, 32'h11C));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h120, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h11C));
        vecs.push_back(mk(1, 3, 8'd0, 0, 32'h0,  32'h124, 0, 4'hF, 1, 0, 1, 1, 2'd0, 32'h11C));
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h0,  32'h128, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h11C));
        // breakpoint at 0x40
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h03C, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h11C));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h040, 1, 4'h0, 0, 1, 1, 0, 2'd2, 32'h40));
        vecs.push_back(mk(1, 3, 8'd0, 1, 32'h40, 32'h040, 1, 4'hF, 1, 0, 0, 0, 2'd2, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h040, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h040, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h044, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h040, 1, 4'h0, 0, 1, 1, 0, 2'd2, 32'h40));
        // HALT and breakpoint together: breakpoint wins
        vecs.push_back(mk(1, 3, 8'd0, 1, 32'h40, 32'h040, 1, 4'hF, 1, 0, 0, 0, 2'd2, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h044, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(1, 1, 8'd0, 1, 32'h40, 32'h040, 1, 4'h0, 0, 1, 1, 0, 2'd2, 32'h40));
        vecs.push_back(mk(1, 3, 8'd0, 1, 32'h40, 32'h048, 1, 4'hF, 1, 0, 0, 0, 2'd2, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h40, 32'h04C, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        // bp_en=0 masks the hit; moving bp_addr takes effect next compare
        vecs.push_back(mk(0, 0, 8'd0, 0, 32'h40, 32'h040, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h80, 32'h040, 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h40));
        vecs.push_back(mk(0, 0, 8'd0, 1, 32'h80, 32'h080, 1, 4'h0, 0, 1, 1, 0, 2'd2, 32'h80));

        // ---- reset ----
        RST = 1'b1;
        drive(0, 2'd0, 8'd0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset", 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h0);
        RST = 1'b0;

        // ---- idle RUN for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            drive(0, 2'd0, 8'd0, 0, 32'h0, 32'h0F0 + 32'(i * 4));
            tick();
            check_all($sformatf("idle%0d", i), 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h0);
        end

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].code, vecs[i].sc, vecs[i].bpen, vecs[i].bpa, vecs[i].pcv);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_dbg, vecs[i].e_en, vecs[i].e_pcen,
                      vecs[i].e_hlt, vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_cause, vecs[i].e_hpc);
        end

        // ---- reset in the middle of a 5-step STEP (controller is HALTED here) ----
        drive(1, 2'd2, 8'd5, 0, 32'h0, 32'h200);
        tick();
        check_all("mid_step1", 1, 4'hF, 1, 0, 0, 0, 2'd2, 32'h80);
        drive(0, 2'd0, 8'd0, 0, 32'h0, 32'h204);
        tick();
        check_all("mid_step2", 1, 4'hF, 1, 0, 0, 0, 2'd2, 32'h80);
        #2;
        RST = 1'b1;
        #1;
        check_all("async_rst", 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 8'd0, 0, 32'h0, 32'h300 + 32'(i * 4));
            tick();
            check_all($sformatf("post_rst%0d", i), 0, 4'hF, 1, 0, 1, 0, 2'd0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
